// File: rtl/ctrl_pkg.sv
// Shared pipeline-control definitions: opcodes, PC-source codes, FSM states, trap causes.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_MTVEC  = 2'd2;
    localparam logic [1:0] PC_MEPC   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_TRAP     = 2'd3
    } ctrl_state_e;

    localparam logic CAUSE_IRQ     = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    // A valid DE instruction that changes control flow this cycle.
    function automatic logic is_redirect(input logic       valid,
                                         input logic [6:0] opcode,
                                         input logic       taken,
                                         input logic       mret);
        return valid && ((opcode == OP_JAL) || (opcode == OP_JALR) ||
                         ((opcode == OP_BRANCH) && taken) || mret);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// MW-to-DE operand bypass compare; purely combinational, x0 never forwards.
module forward_unit (
    input  logic [4:0] mw_rd,
    input  logic       mw_reg_wr,
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    output logic       fwd_a,
    output logic       fwd_b
);

    logic mw_writes;

    assign mw_writes = mw_reg_wr && (mw_rd != 5'd0);
    assign fwd_a     = mw_writes && (mw_rd == de_rs1);
    assign fwd_b     = mw_writes && (mw_rd == de_rs2);

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush/PC-select sequencing for the 3-stage pipeline, with a data-memory wait
// watchdog and trap/MRET handling. Outputs are combinational from state and DE/MW inputs.
module pipeline_controller
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] de_opcode,
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    input  logic       de_valid,
    input  logic       de_is_mret,
    input  logic       branch_taken,
    input  logic [4:0] mw_rd,
    input  logic       mw_reg_wr,
    input  logic       mw_mem_op,
    input  logic       dmem_ready,
    input  logic       irq,
    output logic       stall_if,
    output logic       stall_de,
    output logic       flush_de,
    output logic       flush_mw,
    output logic [1:0] pc_sel,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       trap,
    output logic       trap_cause,
    output logic [1:0] ctrl_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cause_q, cause_d;

    logic       stall_c, flush_de_c, flush_mw_c, trap_c;
    logic [1:0] pc_sel_c;
    logic       fwd_a_c, fwd_b_c;
    logic       redirect;

    assign redirect = is_redirect(de_valid, de_opcode, branch_taken, de_is_mret);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        stall_c    = 1'b0;
        flush_de_c = 1'b0;
        flush_mw_c = 1'b0;
        trap_c     = 1'b0;
        pc_sel_c   = PC_PLUS4;
        case (state_q)
            ST_RUN: begin
                if (mw_mem_op && !dmem_ready) begin
                    stall_c = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_MEM_WAIT;
                end else if (irq && de_valid) begin
                    cause_d = CAUSE_IRQ;
                    state_d = ST_TRAP;
                end else if (redirect) begin
                    pc_sel_c   = de_is_mret ? PC_MEPC : PC_TARGET;
                    flush_de_c = 1'b1;
                    state_d    = ST_REDIRECT;
                end
            end
            ST_MEM_WAIT: begin
                stall_c = 1'b1;
                // A completing access in the last allowed cycle still wins over the watchdog.
                if (dmem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    flush_mw_c = 1'b1;
                    cnt_d      = '0;
                    cause_d    = CAUSE_TIMEOUT;
                    state_d    = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_RUN;
            end
            ST_TRAP: begin
                trap_c     = 1'b1;
                pc_sel_c   = PC_MTVEC;
                flush_de_c = 1'b1;
                flush_mw_c = 1'b1;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            cause_q <= CAUSE_IRQ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    forward_unit u_fwd (
        .mw_rd     (mw_rd),
        .mw_reg_wr (mw_reg_wr),
        .de_rs1    (de_rs1),
        .de_rs2    (de_rs2),
        .fwd_a     (fwd_a_c),
        .fwd_b     (fwd_b_c)
    );

    // Reset forces every control output quiet even while DE/MW inputs are live.
    assign stall_if   = rst_n && stall_c;
    assign stall_de   = rst_n && stall_c;
    assign flush_de   = rst_n && flush_de_c;
    assign flush_mw   = rst_n && flush_mw_c;
    assign trap       = rst_n && trap_c;
    assign fwd_a      = rst_n && fwd_a_c;
    assign fwd_b      = rst_n && fwd_b_c;
    assign pc_sel     = rst_n ? pc_sel_c : PC_PLUS4;
    assign trap_cause = cause_q;
    assign ctrl_state = state_q;

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central sequencing block for the 3-stage RV32I pipeline: IF, DE (decode/execute, where the immediate is generated and the branch is resolved) and MW (memory/writeback). It produces per-stage stall and flush signals, the PC-source select, and the DE operand-forwarding selects. It also runs a data-memory wait state with a timeout watchdog, and sequences trap entry (external interrupt or bus timeout) and MRET return.

Parameters:
TIMEOUT_CYCLES, 16, cycles MEM_WAIT may last before a bus-timeout trap is raised (legal range 2..255)
CNT_W, 8, width of the wait counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
de_opcode  in  7  opcode field [6:0] of the instruction in DE
de_rs1  in  5  rs1 field of the DE instruction
de_rs2  in  5  rs2 field of the DE instruction
de_valid  in  1  DE holds a real (non-bubble) instruction
de_is_mret  in  1  DE instruction is MRET
branch_taken  in  1  DE branch condition is true (valid only for the branch opcode)
mw_rd  in  5  destination register of the MW instruction
mw_reg_wr  in  1  MW instruction writes the register file
mw_mem_op  in  1  MW instruction is a load or store
dmem_ready  in  1  data memory completes the access this cycle
irq  in  1  level-sensitive external interrupt (already masked by the CSR file)
stall_if  out  1  hold PC and the IF/DE register
stall_de  out  1  hold the DE/MW register
flush_de  out  1  turn the IF/DE register into a bubble
flush_mw  out  1  turn the DE/MW register into a bubble
pc_sel  out  2  0 = PC+4, 1 = branch/jump target, 2 = mtvec, 3 = mepc
fwd_a  out  1  DE operand A comes from MW writeback data
fwd_b  out  1  DE operand B comes from MW writeback data
trap  out  1  one-cycle pulse: the CSR file captures DE PC into mepc and records the cause
trap_cause  out  1  0 = interrupt, 1 = bus timeout
ctrl_state  out  2  current FSM state (debug)

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = RUN, wait counter = 0.
  - Every stall, flush, trap, fwd and trap_cause output = 0; pc_sel = 0.
- FSM state encoding: RUN = 0, MEM_WAIT = 1, REDIRECT = 2, TRAP = 3.
- Forwarding is purely combinational and independent of state:
  - fwd_a = mw_reg_wr & (mw_rd != 0) & (mw_rd == de_rs1).
  - fwd_b uses the same rule with de_rs2.
- A DE instruction is a redirect when de_valid is set and any of these holds:
  - opcode 1101111 (JAL);
  - opcode 1100111 (JALR);
  - opcode 1100011 with branch_taken;
  - de_is_mret.
- RUN, evaluated in priority order:
  - (a) mw_mem_op & !dmem_ready: go to MEM_WAIT; assert stall_if and stall_de in this same cycle.
  - (b) irq & de_valid: go to TRAP.
  - (c) redirect: pc_sel = 3 if MRET, otherwise 1; assert flush_de this cycle; go to REDIRECT.
  - (d) otherwise stay in RUN with all outputs 0.
- MEM_WAIT:
  - stall_if = stall_de = 1; the counter increments each cycle.
  - dmem_ready = 1: clear the counter, return to RUN, drop the stalls next cycle. DE is re-evaluated there; a redirect or irq pending in DE is handled then, never lost.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: go to TRAP with cause 1 and flush_mw asserted in the transition cycle. dmem_ready in the same cycle wins over the timeout.
- REDIRECT:
  - One bubble cycle; all outputs 0; unconditionally return to RUN.
  - An irq in this cycle is ignored because DE holds a bubble (de_valid = 0).
- TRAP (exactly 1 cycle):
  - trap = 1, pc_sel = 2, flush_de = flush_mw = 1; trap_cause is the latched cause.
  - Return to RUN.
- Simultaneous events:
  - mem stall beats irq, which beats redirect.
  - irq together with a taken branch: the trap is taken and mepc = DE PC, so the branch re-executes after MRET.
- Reset mid-MEM_WAIT or mid-TRAP: immediate return to RUN with the counter cleared; no trap pulse is emitted.
- trap_cause is a register, loaded on entry to TRAP and held afterwards.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM, OP_IMM, OP_LUI, OP_AUIPC), shared with the immediate generator and decoder;
  - the pc_sel encodings (PC_PLUS4, PC_TARGET, PC_MTVEC, PC_MEPC);
  - the FSM state enum and the cause codes.
- One sub-module, forward_unit, holds the combinational fwd_a/fwd_b compare.

Test Plan:
- Reset release: rst_n low for 3 cycles -> all outputs 0, ctrl_state = 0, pc_sel = 0. Assert rst_n low asynchronously mid-cycle -> outputs clear before the next edge.
- Taken branch: de_opcode = 1100011, branch_taken = 1, de_valid = 1 -> cycle 0: pc_sel = 1, flush_de = 1, ctrl_state = 0. Cycle 1: ctrl_state = 2, outputs 0. Cycle 2: ctrl_state = 0.
- Load wait: mw_mem_op = 1, dmem_ready low for 3 cycles then high -> stall_if = stall_de = 1 for 4 cycles, 0 in the cycle after ready. A JAL held in DE the whole time redirects only after the stall releases.
- Timeout: TIMEOUT_CYCLES = 4, dmem_ready held 0 -> flush_mw on the 4th wait cycle, then trap = 1, trap_cause = 1, pc_sel = 2 for 1 cycle.
- irq with taken branch in DE -> trap = 1, trap_cause = 0, pc_sel = 2, no pc_sel = 1. A following MRET in DE -> pc_sel = 3, flush_de = 1.
- Forwarding: mw_rd = 5, mw_reg_wr = 1, de_rs1 = 5, de_rs2 = 5 -> fwd_a = fwd_b = 1. With mw_rd = 0 -> both 0. With mw_reg_wr = 0 -> both 0.
